// File: rtl/keypad_dispenser.sv
// One-time-pad key store. Software loads nonzero key words and then seals the pad.
// Each word is handed out once over valid/ready, zeroized after use, and never reissued.
module keypad_dispenser #(
    parameter int KEY_W = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [KEY_W-1:0] load_key,
    output logic             load_ready,
    output logic             load_err,
    input  logic             seal,
    output logic             key_valid,
    input  logic             key_ready,
    output logic [KEY_W-1:0] key,
    output logic             key_en,
    output logic [AW:0]      keys_left,
    output logic             exhausted,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] ST_LOAD      = 2'd0;
    localparam logic [1:0] ST_ARMED     = 2'd1;
    localparam logic [1:0] ST_EXHAUSTED = 2'd2;

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [1:0]       state;
    logic [KEY_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;

    logic             load_accept;
    logic             load_zero;
    logic             take;
    logic [AW:0]      keys_after_load;

    // Handshakes: a load transfers when load_valid & load_ready; a key transfers when
    // key_valid & key_ready. key_valid never depends combinationally on key_ready.
    assign load_ready      = (state == ST_LOAD) && (keys_left != CNT_FULL);
    assign load_accept     = load_valid && load_ready && (load_key != '0);
    assign load_zero       = load_valid && load_ready && (load_key == '0);
    assign take            = (state == ST_ARMED) && key_valid && key_ready;
    assign keys_after_load = load_accept ? keys_left + CNT_ONE : keys_left;
    assign rd_next         = rd_ptr + PTR_ONE;

    assign key_en    = key_valid;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_LOAD;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            keys_left <= '0;
            load_err  <= 1'b0;
            key_valid <= 1'b0;
            key       <= '0;
            exhausted <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            load_err <= load_zero;
            case (state)
                ST_LOAD: begin
                    if (load_accept) begin
                        mem[wr_ptr] <= load_key;
                        wr_ptr      <= wr_ptr + PTR_ONE;
                        keys_left   <= keys_after_load;
                    end
                    if (seal) begin
                        if (keys_after_load != '0) begin
                            state     <= ST_ARMED;
                            key_valid <= 1'b1;
                            // A word written in the sealing cycle is not yet visible in mem.
                            key <= (load_accept && (wr_ptr == rd_ptr)) ? load_key : mem[rd_ptr];
                        end else begin
                            state     <= ST_EXHAUSTED;
                            exhausted <= 1'b1;
                        end
                    end
                end
                ST_ARMED: begin
                    if (take) begin
                        mem[rd_ptr] <= '0;
                        rd_ptr      <= rd_next;
                        keys_left   <= keys_left - CNT_ONE;
                        if (keys_left == CNT_ONE) begin
                            state     <= ST_EXHAUSTED;
                            key_valid <= 1'b0;
                            key       <= '0;
                            exhausted <= 1'b1;
                        end else begin
                            key <= mem[rd_next];
                        end
                    end
                end
                ST_EXHAUSTED: begin
                    key_valid <= 1'b0;
                    key       <= '0;
                    exhausted <= 1'b1;
                end
                default: begin
                    state     <= ST_EXHAUSTED;
                    key_valid <= 1'b0;
                    key       <= '0;
                    exhausted <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_dispenser.sv
// Directed bench for keypad_dispenser: load/seal/consume scenarios with hand-computed
// expectations and a queue of expected key words.
module tb_keypad_dispenser;

    localparam int KEY_W = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    localparam logic [1:0] ST_LOAD      = 2'd0;
    localparam logic [1:0] ST_ARMED     = 2'd1;
    localparam logic [1:0] ST_EXHAUSTED = 2'd2;

    logic             clk;
    logic             reset;
    logic             load_valid;
    logic [KEY_W-1:0] load_key;
    logic             load_ready;
    logic             load_err;
    logic             seal;
    logic             key_valid;
    logic             key_ready;
    logic [KEY_W-1:0] key;
    logic             key_en;
    logic [AW:0]      keys_left;
    logic             exhausted;
    logic [1:0]       state_dbg;

    logic [KEY_W-1:0] exp_q[$];
    int               n_checks;
    int               n_fail;

    keypad_dispenser #(.KEY_W(KEY_W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_key   (load_key),
        .load_ready (load_ready),
        .load_err   (load_err),
        .seal       (seal),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key        (key),
        .key_en     (key_en),
        .keys_left  (keys_left),
        .exhausted  (exhausted),
        .state_dbg  (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset      = 1'b0;
        load_valid = 1'b0;
        load_key   = '0;
        seal       = 1'b0;
        key_ready  = 1'b0;
        exp_q.delete();
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic load_word(input logic [KEY_W-1:0] k);
        load_valid = 1'b1;
        load_key   = k;
        tick();
        load_valid = 1'b0;
        load_key   = '0;
    endtask

    task automatic do_seal();
        seal = 1'b1;
        tick();
        seal = 1'b0;
    endtask

    // Scoreboard: consume n words back-to-back, comparing against exp_q.
    task automatic consume_n(input int n, input string tag);
        logic [KEY_W-1:0] exp;
        key_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            exp = exp_q.pop_front();
            check({tag, "_valid"}, 64'(key_valid), 64'd1);
            check({tag, "_key"}, 64'(key), 64'(exp));
            tick();
        end
        key_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset state
        apply_reset();
        check("rst_key", 64'(key), 64'd0);
        check("rst_valid", 64'(key_valid), 64'd0);
        check("rst_key_en", 64'(key_en), 64'd0);
        check("rst_load_err", 64'(load_err), 64'd0);
        check("rst_exhausted", 64'(exhausted), 64'd0);
        check("rst_load_ready", 64'(load_ready), 64'd1);
        check("rst_keys_left", 64'(keys_left), 64'd0);
        check("rst_state", 64'(state_dbg), 64'(ST_LOAD));

        // T1: three keys, consumed in three consecutive cycles
        load_word(32'hA5A5_A5A5); exp_q.push_back(32'hA5A5_A5A5);
        load_word(32'h0000_FFFF); exp_q.push_back(32'h0000_FFFF);
        load_word(32'h1234_5678); exp_q.push_back(32'h1234_5678);
        check("t1_keys_left", 64'(keys_left), 64'd3);
        do_seal();
        check("t1_state_armed", 64'(state_dbg), 64'(ST_ARMED));
        check("t1_load_ready", 64'(load_ready), 64'd0);
        check("t1_key_en", 64'(key_en), 64'd1);
        consume_n(3, "t1");
        check("t1_exhausted", 64'(exhausted), 64'd1);
        check("t1_keys_left_end", 64'(keys_left), 64'd0);
        check("t1_valid_end", 64'(key_valid), 64'd0);
        check("t1_key_end", 64'(key), 64'd0);
        load_word(32'hDEAD_BEEF);
        do_seal();
        check("t1_exh_ignores_load", 64'(keys_left), 64'd0);
        check("t1_exh_state", 64'(state_dbg), 64'(ST_EXHAUSTED));

        // T2: zero key dropped with one-cycle error pulse; seal empty
        apply_reset();
        load_word('0);
        check("t2_load_err", 64'(load_err), 64'd1);
        check("t2_keys_left", 64'(keys_left), 64'd0);
        tick();
        check("t2_load_err_clear", 64'(load_err), 64'd0);
        do_seal();
        check("t2_exhausted", 64'(exhausted), 64'd1);
        for (int i = 0; i < 3; i++) begin
            check("t2_valid_never", 64'(key_valid), 64'd0);
            tick();
        end

        // T3: seventeen loads into a sixteen-word pad
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            load_word(32'h1000_0000 + 32'(i));
            exp_q.push_back(32'h1000_0000 + 32'(i));
        end
        check("t3_load_ready_full", 64'(load_ready), 64'd0);
        check("t3_keys_left_full", 64'(keys_left), 64'd16);
        load_word(32'h2000_0000);
        check("t3_17th_dropped", 64'(keys_left), 64'd16);
        check("t3_no_err_when_full", 64'(load_err), 64'd0);
        do_seal();
        consume_n(DEPTH, "t3");
        check("t3_exhausted", 64'(exhausted), 64'd1);
        check("t3_keys_left_end", 64'(keys_left), 64'd0);

        // T4: consumer stalls for 10 cycles
        apply_reset();
        load_word(32'hA5A5_A5A5);
        load_word(32'h5A5A_5A5A);
        do_seal();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_stall_key", 64'(key), 64'hA5A5_A5A5);
            check("t4_stall_left", 64'(keys_left), 64'd2);
        end
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        check("t4_next_key", 64'(key), 64'h5A5A_5A5A);
        check("t4_next_left", 64'(keys_left), 64'd1);
        tick();
        check("t4_hold_after_pulse", 64'(key), 64'h5A5A_5A5A);

        // T5: load and seal in the same cycle from empty
        apply_reset();
        load_valid = 1'b1;
        load_key   = 32'h0000_0001;
        seal       = 1'b1;
        tick();
        load_valid = 1'b0;
        seal       = 1'b0;
        check("t5_state", 64'(state_dbg), 64'(ST_ARMED));
        check("t5_key", 64'(key), 64'h1);
        check("t5_left", 64'(keys_left), 64'd1);
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        check("t5_exhausted", 64'(exhausted), 64'd1);
        check("t5_valid_end", 64'(key_valid), 64'd0);

        // T6: asynchronous reset mid-ARMED, then reload
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            load_word(32'hC000_0000 + 32'(i));
            exp_q.push_back(32'hC000_0000 + 32'(i));
        end
        do_seal();
        consume_n(2, "t6_pre");
        key_ready = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_key", 64'(key), 64'd0);
        check("t6_async_valid", 64'(key_valid), 64'd0);
        check("t6_async_left", 64'(keys_left), 64'd0);
        check("t6_async_state", 64'(state_dbg), 64'(ST_LOAD));
        key_ready = 1'b0;
        exp_q.delete();
        tick();
        reset = 1'b1;
        tick();
        load_word(32'hB100_0001); exp_q.push_back(32'hB100_0001);
        load_word(32'hB200_0002); exp_q.push_back(32'hB200_0002);
        do_seal();
        check("t6_reload_left", 64'(keys_left), 64'd2);
        consume_n(2, "t6_post");
        check("t6_exhausted", 64'(exhausted), 64'd1);
        check("t6_key_cleared", 64'(key), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
